// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Operand-forwarding selects and load-use stall control for a 5-stage RV32
// pipeline. Sits between the ID decoder and the ID/EX register: it watches
// the instruction in ID against the producers currently in EX and MEM and
// produces the EX-stage mux selects one cycle later, together with the
// instruction.
//
// Select codes: 0 = regfile, 1 = EX/MEM ALU result, 2 = MEM/WB data.
// Code 3 is never driven.
//
// The writeback-stage producer is not held here. The regfile is write-first,
// so an instruction in WB never needs forwarding. For the same reason the MEM
// entry only keeps the fields that the select logic consumes.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_bubble,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    // In-flight instruction summary. A bubble is all zeros.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              mr;
    } stage_t;

    stage_t            ex_q, ex_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;

    logic              ex_bubble_q, ex_bubble_d;
    logic [1:0]        fwd_a_q, fwd_a_d;
    logic [1:0]        fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              load_use;
    logic              kill;
    logic [1:0]        sel_a, sel_b;

    // Load-use detection: a load in EX whose rd feeds the ID instruction.
    // A flush kills the ID instruction, so it cannot stall.
    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_q.valid && ex_q.mr && (ex_q.rd != '0) && !ex_flush) begin
            if ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                (id_rs2_used && (id_rs2 == ex_q.rd))) begin
                load_use = 1'b1;
            end
        end
    end

    // Forwarding source per operand; the younger (EX) producer wins.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (id_rs1_used && (id_rs1 != '0)) begin
            if (ex_q.valid && ex_q.we && (ex_q.rd == id_rs1)) begin
                sel_a = SEL_EXMEM;
            end else if (mem_valid_q && mem_we_q && (mem_rd_q == id_rs1)) begin
                sel_a = SEL_MEMWB;
            end
        end
        if (id_rs2_used && (id_rs2 != '0)) begin
            if (ex_q.valid && ex_q.we && (ex_q.rd == id_rs2)) begin
                sel_b = SEL_EXMEM;
            end else if (mem_valid_q && mem_we_q && (mem_rd_q == id_rs2)) begin
                sel_b = SEL_MEMWB;
            end
        end
    end

    // Next-state for the pipeline tracking, EX controls and stall counter.
    always_comb begin
        kill        = load_use || ex_flush || !id_valid;
        ex_d        = '0;
        ex_bubble_d = 1'b1;
        fwd_a_d     = SEL_RF;
        fwd_b_d     = SEL_RF;
        if (!kill) begin
            ex_d        = {1'b1, id_rd, id_regwrite, id_memread};
            ex_bubble_d = 1'b0;
            fwd_a_d     = sel_a;
            fwd_b_d     = sel_b;
        end
        mem_valid_d = ex_q.valid;
        mem_rd_d    = ex_q.rd;
        mem_we_d    = ex_q.we;
        stall_cnt_d = stall_cnt_q;
        if (load_use && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset leaves every stage as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            ex_bubble_q <= 1'b1;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            ex_bubble_q <= ex_bubble_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall        = load_use;
    assign ex_bubble    = ex_bubble_q;
    assign ex_fwd_a_sel = fwd_a_q;
    assign ex_fwd_b_sel = fwd_b_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed hazard scenarios followed by random
// instruction streams, all compared against a queue-based model of the
// instructions in flight.
module tb_fwd_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_flush;
    logic        stall;
    logic        ex_bubble;
    logic [1:0]  ex_fwd_a_sel;
    logic [1:0]  ex_fwd_b_sel;
    logic [31:0] stall_cnt;

    int n_checks;
    int n_errors;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .ex_fwd_a_sel (ex_fwd_a_sel),
        .ex_fwd_b_sel (ex_fwd_b_sel),
        .stall_cnt    (stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instructions in flight, index 0 = youngest (in EX), 1 = in MEM.
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       mr;
    } ent_t;

    ent_t        pipe_q[$];
    bit [31:0]   exp_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t b;
        b = '{valid: 1'b0, rd: 5'd0, we: 1'b0, mr: 1'b0};
        pipe_q.delete();
        pipe_q.push_back(b);
        pipe_q.push_back(b);
        exp_cnt = 32'd0;
    endtask

    // Distance (1 or 2) to the youngest in-flight producer of rs, or 0.
    function automatic bit [1:0] producer_dist(input bit used, input bit [4:0] rs);
        if (!used || rs == 5'd0) return 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (pipe_q[i].valid && pipe_q[i].we && pipe_q[i].rd == rs) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    // Drive one ID-stage slot for one cycle and check stall and EX outputs.
    task automatic step(input bit v, input bit [4:0] rs1, input bit u1,
                        input bit [4:0] rs2, input bit u2,
                        input bit [4:0] rd, input bit we, input bit mr, input bit fl);
        bit       exp_stall;
        bit       kill;
        bit [1:0] exp_a, exp_b;
        ent_t     e;
        @(negedge clk);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwrite = we; id_memread = mr; ex_flush = fl;
        #1;
        exp_stall = v && !fl && pipe_q[0].valid && pipe_q[0].mr && pipe_q[0].rd != 5'd0 &&
                    ((u1 && rs1 == pipe_q[0].rd) || (u2 && rs2 == pipe_q[0].rd));
        check_eq("stall", stall, exp_stall);
        kill  = exp_stall || fl || !v;
        exp_a = kill ? 2'd0 : producer_dist(u1, rs1);
        exp_b = kill ? 2'd0 : producer_dist(u2, rs2);
        if (kill) e = '{valid: 1'b0, rd: 5'd0, we: 1'b0, mr: 1'b0};
        else      e = '{valid: 1'b1, rd: rd, we: we, mr: mr};
        if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        @(posedge clk);
        pipe_q.push_front(e);
        void'(pipe_q.pop_back());
        #1;
        check_eq("ex_bubble", ex_bubble, kill);
        check_eq("sel_a", ex_fwd_a_sel, exp_a);
        check_eq("sel_b", ex_fwd_b_sel, exp_b);
        check_eq("stall_cnt", stall_cnt, exp_cnt);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_stall"}, stall, 1'b0);
        check_eq({tag, "_bubble"}, ex_bubble, 1'b1);
        check_eq({tag, "_sel_a"}, ex_fwd_a_sel, 2'd0);
        check_eq({tag, "_sel_b"}, ex_fwd_b_sel, 2'd0);
        check_eq({tag, "_cnt"}, stall_cnt, 32'd0);
    endtask

    // Assert reset between edges with a load-use pair pending; outputs must
    // drop to reset values without waiting for a clock.
    task automatic mid_reset();
        step(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 1, 0);         // lw x9
        @(negedge clk);
        id_valid = 1; id_rs1 = 5'd9; id_rs1_used = 1; id_rs2 = 5'd0; id_rs2_used = 0;
        id_rd = 5'd10; id_regwrite = 1; id_memread = 0; ex_flush = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 0);        // reader after reset: no forwarding
    endtask

    // Stimulus
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; ex_flush = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // add x5 ; sub rs1=x5 -> sel_a=1
        step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        step(1, 5'd5, 1, 5'd6, 1, 5'd8, 1, 0, 0);
        check_eq("dir_exmem_a", ex_fwd_a_sel, 2'd1);
        // add x5 ; nop ; or rs2=x5 -> sel_b=2
        step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        step(1, 5'd6, 1, 5'd5, 1, 5'd8, 1, 0, 0);
        check_eq("dir_memwb_b", ex_fwd_b_sel, 2'd2);
        // lw x7 ; add rs1=x7 -> one stall, then sel_a=2
        step(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        step(1, 5'd7, 1, 5'd3, 1, 5'd8, 1, 0, 0);
        check_eq("dir_lu_bubble", ex_bubble, 1'b1);
        check_eq("dir_lu_cnt", stall_cnt, 32'd1);
        step(1, 5'd7, 1, 5'd3, 1, 5'd8, 1, 0, 0);
        check_eq("dir_lu_sel_a", ex_fwd_a_sel, 2'd2);
        // add x3 ; add x3 ; xor x3,x3 -> both sels 1
        step(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
        step(1, 5'd4, 1, 5'd2, 1, 5'd3, 1, 0, 0);
        step(1, 5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0);
        check_eq("dir_young_a", ex_fwd_a_sel, 2'd1);
        check_eq("dir_young_b", ex_fwd_b_sel, 2'd1);
        // lw x0 ; add rs1=x0 -> no stall, sel 0
        step(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0);
        step(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0);
        check_eq("dir_x0_sel_a", ex_fwd_a_sel, 2'd0);
        // lw x7 ; dependent add with flush -> no stall, bubble, count unchanged
        step(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0);
        step(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 1);
        check_eq("dir_flush_bubble", ex_bubble, 1'b1);
        check_eq("dir_flush_cnt", stall_cnt, 32'd1);

        // Random streams over a small register set to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) mid_reset();
            step($urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
